// File: rtl/game_pkg.sv
// Shared definitions for the round controller and its score bank.
//   NUM_PLAYERS / SCORE_W : player count and per-player score width
//   round_state_t         : round sequencing states
//   popcount4             : number of set bits in a 4-bit player mask
package game_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int SCORE_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PLAY,
        ST_RESULT
    } round_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/game_round_ctrl_score_bank.sv
// score_bank: one saturating win counter per player.
//   clk_i, rst_i : clock, async active-low reset (counters cleared)
//   inc_i        : one-hot increment request, one bit per player
//   scores_o     : packed counters, player n at [n*SCORE_W +: SCORE_W]
module score_bank
    import game_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PLAYERS-1:0]         inc_i,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o
);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_cnt
        logic [SCORE_W-1:0] cnt_q, cnt_d;

        // Hold at all-ones instead of wrapping.
        always_comb begin
            cnt_d = cnt_q;
            if (inc_i[g] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign scores_o[g*SCORE_W +: SCORE_W] = cnt_q;
    end

endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: sequences game rounds around the countdown block.
//   clk_i, rst_i       : clock, async active-low reset
//   start_btn_i        : single-cycle start / abort / restart request
//   line_type_i        : countdown run flag, 1 = round in play
//   active_players_i   : enabled-player mask from the countdown block
//   crash_i            : per-player single-cycle crash pulses
//   new_game_o         : single-cycle new-round request to countdown block
//   alive_o            : players still alive this round
//   winner_o           : one-hot winner, 0 = draw
//   winner_valid_o     : result valid
//   scores_o           : four 4-bit saturating win counters
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned EndHold     = 200_000_000,
    parameter bit          AutoRestart = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_btn_i,
    input  logic                           line_type_i,
    input  logic [NUM_PLAYERS-1:0]         active_players_i,
    input  logic [NUM_PLAYERS-1:0]         crash_i,
    output logic                           new_game_o,
    output logic [NUM_PLAYERS-1:0]         alive_o,
    output logic [NUM_PLAYERS-1:0]         winner_o,
    output logic                           winner_valid_o,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o
);

    round_state_t           state_q, state_d;
    logic [NUM_PLAYERS-1:0] act_q, act_d;
    logic [NUM_PLAYERS-1:0] alive_q, alive_d;
    logic [NUM_PLAYERS-1:0] winner_q, winner_d;
    logic                   wvalid_q, wvalid_d;
    logic                   new_game_q, new_game_d;
    logic [31:0]            hold_q, hold_d;
    logic [NUM_PLAYERS-1:0] inc;
    logic [NUM_PLAYERS-1:0] alive_nxt;
    logic [2:0]             thresh;
    logic                   do_restart;

    // Survivors after this cycle's crashes; crashes of locked-out players ignored.
    assign alive_nxt = alive_q & ~(crash_i & act_q);
    // A multi-player round ends at one survivor, a solo round at none.
    assign thresh    = (popcount4(act_q) >= 3'd2) ? 3'd1 : 3'd0;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        alive_d    = alive_q;
        winner_d   = winner_q;
        wvalid_d   = wvalid_q;
        hold_d     = hold_q;
        new_game_d = 1'b0;
        inc        = '0;
        do_restart = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_btn_i && (active_players_i != '0)) do_restart = 1'b1;
            end
            ST_ARMED: begin
                if (line_type_i) begin
                    alive_d = active_players_i;
                    act_d   = active_players_i;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Abort outranks both a dropped run flag and a same-cycle crash.
                if (start_btn_i) begin
                    do_restart = 1'b1;
                end else if (!line_type_i) begin
                    state_d = ST_IDLE;
                end else begin
                    alive_d = alive_nxt;
                    if (popcount4(alive_nxt) <= thresh) begin
                        state_d  = ST_RESULT;
                        wvalid_d = 1'b1;
                        winner_d = (popcount4(alive_nxt) == 3'd1) ? alive_nxt : '0;
                        inc      = (popcount4(alive_nxt) == 3'd1) ? alive_nxt : '0;
                        hold_d   = '0;
                    end
                end
            end
            ST_RESULT: begin
                if (start_btn_i) begin
                    do_restart = 1'b1;
                end else if (hold_q == EndHold - 1) begin
                    hold_d = '0;
                    if (AutoRestart) do_restart = 1'b1;
                    else             state_d    = ST_IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every new round request wipes the previous round's visible state.
        if (do_restart) begin
            new_game_d = 1'b1;
            alive_d    = '0;
            winner_d   = '0;
            wvalid_d   = 1'b0;
            hold_d     = '0;
            state_d    = ST_ARMED;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            act_q      <= '0;
            alive_q    <= '0;
            winner_q   <= '0;
            wvalid_q   <= 1'b0;
            new_game_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            alive_q    <= alive_d;
            winner_q   <= winner_d;
            wvalid_q   <= wvalid_d;
            new_game_q <= new_game_d;
            hold_q     <= hold_d;
        end
    end

    score_bank u_score_bank (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (inc),
        .scores_o (scores_o)
    );

    assign new_game_o     = new_game_q;
    assign alive_o        = alive_q;
    assign winner_o       = winner_q;
    assign winner_valid_o = wvalid_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

    localparam int HOLD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_btn_i = 1'b0;
    logic        line_type_i = 1'b0;
    logic [3:0]  active_players_i = '0;
    logic [3:0]  crash_i = '0;
    logic        new_game_o;
    logic [3:0]  alive_o;
    logic [3:0]  winner_o;
    logic        winner_valid_o;
    logic [15:0] scores_o;

    int n_vec = 0;
    int n_err = 0;

    game_round_ctrl #(.EndHold(HOLD), .AutoRestart(1'b1)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_btn_i      (start_btn_i),
        .line_type_i      (line_type_i),
        .active_players_i (active_players_i),
        .crash_i          (crash_i),
        .new_game_o       (new_game_o),
        .alive_o          (alive_o),
        .winner_o         (winner_o),
        .winner_valid_o   (winner_valid_o),
        .scores_o         (scores_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st;
        logic        lt;
        logic [3:0]  act;
        logic [3:0]  cr;
        logic        ng;
        logic [3:0]  alive;
        logic [3:0]  win;
        logic        wv;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl [22];

    function automatic logic [25:0] pack(logic ng, logic [3:0] al, logic [3:0] w,
                                         logic v, logic [15:0] s);
        return {ng, al, w, v, s};
    endfunction

    task automatic chk(input string name, input logic [25:0] got, input logic [25:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ng=%b alive=%b win=%b wv=%b sc=%h, want ng=%b alive=%b win=%b wv=%b sc=%h",
                     name, got[25], got[24:21], got[20:17], got[16], got[15:0],
                     exp[25], exp[24:21], exp[20:17], exp[16], exp[15:0]);
        end
    endtask

    function automatic logic [25:0] dut_out();
        return pack(new_game_o, alive_o, winner_o, winner_valid_o, scores_o);
    endfunction

    // Apply one cycle of inputs; outputs are looked at 1 ns after the edge.
    task automatic step(input logic st, input logic lt, input logic [3:0] act, input logic [3:0] cr);
        @(negedge clk_i);
        start_btn_i      = st;
        line_type_i      = lt;
        active_players_i = act;
        crash_i          = cr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        start_btn_i = 1'b0; line_type_i = 1'b0; active_players_i = '0; crash_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // ---------------- reference model: round described by its rules ----------------
    localparam int P_IDLE = 0, P_ARMED = 1, P_PLAY = 2, P_RESULT = 3;
    int         m_phase;
    logic [3:0] m_mask, m_alive, m_win;
    logic       m_wv, m_ng;
    int         m_left;
    int         m_score [4];

    task automatic model_reset();
        m_phase = P_IDLE; m_mask = '0; m_alive = '0; m_win = '0; m_wv = 0; m_ng = 0; m_left = 0;
        for (int i = 0; i < 4; i++) m_score[i] = 0;
    endtask

    task automatic model_new_round();
        m_ng = 1; m_alive = '0; m_win = '0; m_wv = 0; m_phase = P_ARMED;
    endtask

    task automatic model_step(input logic st, input logic lt, input logic [3:0] act, input logic [3:0] cr);
        int need, left_cnt;
        m_ng = 0;
        if (m_phase == P_IDLE) begin
            if (st && act != 0) model_new_round();
        end else if (m_phase == P_ARMED) begin
            if (lt) begin m_alive = act; m_mask = act; m_phase = P_PLAY; end
        end else if (m_phase == P_PLAY) begin
            if (st) model_new_round();
            else if (!lt) m_phase = P_IDLE;
            else begin
                m_alive  = m_alive & ~(cr & m_mask);
                need     = ($countones(m_mask) >= 2) ? 1 : 0;
                left_cnt = $countones(m_alive);
                if (left_cnt <= need) begin
                    m_phase = P_RESULT;
                    m_wv    = 1;
                    m_win   = (left_cnt == 1) ? m_alive : 4'b0;
                    for (int i = 0; i < 4; i++)
                        if (m_win[i] && m_score[i] < 15) m_score[i]++;
                    m_left = HOLD;
                end
            end
        end else begin
            if (st) model_new_round();
            else begin
                m_left--;
                if (m_left == 0) model_new_round();
            end
        end
    endtask

    function automatic logic [15:0] model_scores();
        logic [15:0] s;
        for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'(m_score[i]);
        return s;
    endfunction

    initial begin
        // st lt act cr | ng alive win wv scores
        tbl[0]  = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 4'h7, 4'h0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 4'h6, 4'h0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 4'h6, 4'h0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 4'h7, 4'h4, 1'b0, 4'h2, 4'h2, 1'b1, 16'h0010};
        tbl[6]  = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 16'h0010};
        tbl[7]  = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 16'h0010};
        tbl[8]  = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 16'h0010};
        tbl[9]  = '{1'b0, 1'b0, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0010};
        tbl[10] = '{1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 4'h3, 4'h0, 1'b0, 16'h0010};
        tbl[11] = '{1'b0, 1'b1, 4'h3, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'h0010};
        tbl[12] = '{1'b1, 1'b1, 4'h8, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0010};
        tbl[13] = '{1'b0, 1'b1, 4'h8, 4'h0, 1'b0, 4'h8, 4'h0, 1'b0, 16'h0010};
        tbl[14] = '{1'b0, 1'b1, 4'h8, 4'h1, 1'b0, 4'h8, 4'h0, 1'b0, 16'h0010};
        tbl[15] = '{1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 4'h0, 1'b1, 16'h0010};
        tbl[16] = '{1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0010};
        tbl[17] = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 4'h7, 4'h0, 1'b0, 16'h0010};
        tbl[18] = '{1'b1, 1'b1, 4'h7, 4'h6, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0010};
        tbl[19] = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 16'h0010};
        tbl[20] = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0, 16'h0010};
        tbl[21] = '{1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b1, 16'h0010};

        // Reset state, checked while reset is held.
        @(negedge clk_i);
        #1;
        chk("reset_state", dut_out(), 26'h0);
        do_reset();

        // Win, auto-restart after hold, draw, restart in result, solo round, abort.
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].st, tbl[i].lt, tbl[i].act, tbl[i].cr);
            chk($sformatf("table_%0d", i), dut_out(),
                pack(tbl[i].ng, tbl[i].alive, tbl[i].win, tbl[i].wv, tbl[i].sc));
        end

        // Start with no active players is ignored.
        do_reset();
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk("idle_no_players", dut_out(), 26'h0);
        step(1'b0, 1'b1, 4'h5, 4'h0);
        chk("idle_stays_idle", dut_out(), 26'h0);

        // Reset while playing clears everything, including scores.
        step(1'b1, 1'b0, 4'h3, 4'h0);
        step(1'b0, 1'b1, 4'h3, 4'h0);
        step(1'b0, 1'b1, 4'h3, 4'h2);
        chk("pre_reset_win", dut_out(), pack(1'b0, 4'h1, 4'h1, 1'b1, 16'h0001));
        step(1'b1, 1'b1, 4'h3, 4'h0);
        step(1'b0, 1'b1, 4'h3, 4'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_mid_play", dut_out(), 26'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Player 0 wins 16 rounds; counter must stop at 15.
        step(1'b1, 1'b0, 4'h3, 4'h0);
        for (int r = 0; r < 16; r++) begin
            step(1'b0, 1'b1, 4'h3, 4'h0);
            step(1'b0, 1'b1, 4'h3, 4'h2);
            chk($sformatf("sat_round_%0d", r), dut_out(),
                pack(1'b0, 4'h1, 4'h1, 1'b1, 16'((r < 15) ? r + 1 : 15)));
            step(1'b1, 1'b1, 4'h3, 4'h0);
        end

        // Randomized traffic against the rule-level model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       st, lt;
            logic [3:0] act, cr;
            st  = ($urandom_range(0, 24) == 0);
            lt  = ($urandom_range(0, 59) != 0);
            act = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) cr[b] = ($urandom_range(0, 5) == 0);
            step(st, lt, act, cr);
            model_step(st, lt, act, cr);
            chk($sformatf("rand_%0d", c), dut_out(),
                pack(m_ng, m_alive, m_win, m_wv, model_scores()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round-sequencing controller that closes the loop around the game-start countdown block. It issues the `new_game` request pulse and watches the `line_type` run flag that the countdown block returns. It latches the active-player mask and tracks which players are still alive from per-player crash events. It also declares the winner, keeps saturating win counts, and optionally re-arms the next round after a result-hold interval.

## Interface
- `EndHold`, default 200_000_000: cycles the result is held before auto-restart (2 s at 100 MHz); must be ≥1.
- `AutoRestart`, default 1: 1 = issue `new_game_o` automatically after `EndHold`; 0 = return to IDLE and wait for button.
- `clk_i` input 1: system clock.
- `rst_i` input 1: reset, asynchronous, active-low.
- `start_btn_i` input 1: debounced, synchronized single-cycle start/abort request.
- `line_type_i` input 1: run flag from countdown block; 1 = round in play.
- `active_players_i` input 4: enabled-player mask from countdown block.
- `crash_i` input 4: per-player single-cycle crash pulses from collision logic.
- `new_game_o` output 1: single-cycle pulse requesting a new round (drives countdown block `new_game`).
- `alive_o` output 4: players still alive in the current round.
- `winner_o` output 4: one-hot winner; 0 = draw.
- `winner_valid_o` output 1: result valid.
- `scores_o` output 16: four 4-bit win counters; player n occupies bits [4n+3:4n].

## Operation
- States: IDLE, ARMED, PLAY, RESULT.
- **IDLE:**
  - `start_btn_i` with `active_players_i != 0` → pulse `new_game_o`, go ARMED.
  - `start_btn_i` with `active_players_i == 0` → ignored.
- **ARMED:**
  - Waits for `line_type_i` to go 1.
  - On that cycle: load `alive` ← `active_players_i`, lock the mask internally (`act_q`), go PLAY.
  - Crashes are ignored in ARMED.
- **PLAY:**
  - Each cycle: `alive` ← `alive & ~crash_i`. Crash bits outside `act_q` are ignored.
  - Game over when popcount(next alive) ≤ threshold. Threshold = 1 if popcount(`act_q`) ≥ 2, else 0.
  - On game over, go RESULT:
    - One survivor → `winner_o` = that bit, its score +1, saturating at 15.
    - Zero survivors (simultaneous final crashes) → `winner_o` = 0, no score change.
  - `start_btn_i` in PLAY = abort: pulse `new_game_o`, go ARMED, no result, no score. Abort has priority over a same-cycle crash.
  - `line_type_i` falling in PLAY (unexpected) → go IDLE, no result.
- **RESULT:**
  - `winner_valid_o` = 1; the hold counter counts to `EndHold`-1.
  - `AutoRestart` = 1 → at terminal count, pulse `new_game_o` and go ARMED.
  - `AutoRestart` = 0 → at terminal count, go IDLE; `winner_valid_o`/`winner_o` persist until the next `new_game_o`.
  - `start_btn_i` in RESULT → immediate restart (pulse, ARMED), hold counter cleared.
- `winner_valid_o`, `winner_o` and `alive_o` clear in the same cycle `new_game_o` is asserted.
- `scores_o` clears only on reset.

## Timing
- Reset values:
  - `new_game_o`=0, `alive_o`=0, `winner_o`=0, `winner_valid_o`=0, `scores_o`=0.
  - State IDLE; hold counter 0.
- All outputs are registered.
- `new_game_o` rises one cycle after the sampled `start_btn_i` or the hold terminal count, and is high exactly one cycle.
- `alive_o` updates one cycle after the crash pulse.
- `winner_valid_o` and the score increment appear in the same cycle, one cycle after the ending crash.
- RESULT lasts exactly `EndHold` cycles before the restart pulse (AutoRestart=1).
- `line_type_i` is sampled level-wise in ARMED. There is no timeout: the countdown block guarantees it rises.
- Reset mid-round returns to IDLE at once, scores zeroed.

## Structure
- Shared package `game_pkg`:
  - `NUM_PLAYERS`=4 and `SCORE_W`=4.
  - State enum `round_state_t`.
  - Function `popcount4`.
- Sub-module `score_bank`: four saturating `SCORE_W` counters with a one-hot increment input and async active-low reset; output is the packed `scores_o`.
- Hold counter is 32-bit; it is compared against `EndHold`-1.

## Test plan
All scenarios use `EndHold`=4.
- **Basic win:** reset; `active_players_i`=4'b0111; `start_btn_i` pulse → `new_game_o` one cycle later. Raise `line_type_i`; crash 4'b0001, then 4'b0100 → `winner_o`=4'b0010, `winner_valid_o`=1, `scores_o`[7:4]=1. With AutoRestart=1, `new_game_o` pulses exactly 4 cycles later.
- **Draw:** active 4'b0011; simultaneous crash 4'b0011 → `winner_o`=0, `winner_valid_o`=1, `scores_o` unchanged.
- **Single player:** active 4'b1000; crash 4'b1000 → draw. Crash 4'b0001 (inactive) earlier has no effect on `alive_o`.
- **Abort:** in PLAY, `start_btn_i` together with the final crash → `new_game_o` pulse, state ARMED, no score change, `winner_valid_o`=0.
- **Saturation:** player 0 wins 16 rounds → `scores_o`[3:0]=15.
- **Idle guards:** `start_btn_i` with active 4'b0000 → no pulse. Reset asserted mid-PLAY → all outputs 0.
